instruction_fetch: RTL

- Fetch/PC stage feeding the control unit and register file: holds the PC, issues requests to instruction memory, presents the instruction to decode, and computes the next PC.
- Next-PC selection uses the Branch/Jump decode, the branch condition, the sign-extended immediate and the rs value.
- A req/ack handshake with instruction memory supports multi-cycle memories; the core signals retirement with `commit`.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/next_pc_sel.sv | 31 +++
 rtl/instruction_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch FSM encoding, opcode/funct
// constants used by the control unit, and the default reset PC.
package mips_pkg;

   typedef logic [2:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE   = 3'd0;
   localparam fetch_state_t ST_FETCH  = 3'd1;
   localparam fetch_state_t ST_EXEC   = 3'd2;
   localparam fetch_state_t ST_HALTED = 3'd3;
   localparam fetch_state_t ST_FAULT  = 3'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: register jump, absolute jump, taken
// branch, or sequential fall-through, plus an alignment flag on the result.
module next_pc_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic [31:0] imm,
   input  logic [25:0] jtarget,
   input  logic [31:0] rs_value,
   output logic [31:0] next_pc,
   output logic        misaligned_next
);

   always_comb begin
      next_pc = pc_plus4;
      if (jump && jump_reg) begin
         next_pc = rs_value;
      end else if (jump) begin
         next_pc = {pc_plus4[31:28], jtarget, 2'b00};
      end else if (branch && branch_taken) begin
         next_pc = pc_plus4 + (imm << 2);
      end
   end

   assign misaligned_next = !is_word_aligned(next_pc);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch/PC stage: owns the PC, runs the req/ack fetch handshake, holds the
// instruction for decode until commit, then advances, halts or faults.
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   input  logic              commit,
   input  logic              branch,
   input  logic              branch_taken,
   input  logic              jump,
   input  logic              jump_reg,
   input  logic [31:0]       imm,
   input  logic [25:0]       jtarget,
   input  logic [31:0]       rs_value,
   input  logic              halt,
   output logic              misaligned,
   output logic              halted
);

   fetch_state_t state;
   logic [31:0]  next_pc;
   logic         misaligned_next;

   assign imem_req    = (state == ST_FETCH);
   assign instr_valid = (state == ST_EXEC);
   assign halted      = (state == ST_HALTED) || (state == ST_FAULT);
   assign imem_addr   = pc;
   assign pc_plus4    = pc + ADDR_W'(4);

   next_pc_sel u_next_pc_sel (
      .pc_plus4        (pc_plus4),
      .branch          (branch),
      .branch_taken    (branch_taken),
      .jump            (jump),
      .jump_reg        (jump_reg),
      .imm             (imm),
      .jtarget         (jtarget),
      .rs_value        (rs_value),
      .next_pc         (next_pc),
      .misaligned_next (misaligned_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         instr      <= '0;
         misaligned <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_FETCH;
            ST_FETCH: begin
               if (imem_ack) begin
                  instr <= imem_rdata;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (commit) begin
                  // A misaligned target leaves pc on the faulting instruction.
                  if (misaligned_next) begin
                     misaligned <= 1'b1;
                     state      <= ST_FAULT;
                  end else begin
                     pc    <= next_pc;
                     state <= halt ? ST_HALTED : ST_FETCH;
                  end
               end
            end
            default: state <= state;
         endcase
      end
   end

endmodule
